// File: rtl/alu_pkg.sv
// Shared definitions for the sequential WISC ALU: op encodings, FSM states
// and the overflow rule used by the adder.
package alu_pkg;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_ROR = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Signed overflow looks at operand/result sign bits; unsigned overflow is
    // the carry-out, flipped once for each inverted operand so that a
    // subtraction (invB) reports a borrow rather than a carry.
    function automatic logic addOverflow(
        input logic isSigned,
        input logic aMsb,
        input logic bMsb,
        input logic sumMsb,
        input logic cout,
        input logic invA,
        input logic invB
    );
        if (isSigned) begin
            return (aMsb == bMsb) && (sumMsb != aMsb);
        end
        return cout ^ (invA ^ invB);
    endfunction

endpackage

// File: rtl/alu_core_comb.sv
// Combinational arithmetic/logic core: ADD, OR, XOR, AND on operands that
// have already been conditionally inverted. Shift ops yield zero here; the
// parent handles them.
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [2:0]       op_i,
    input  logic             sign_i,
    input  logic             invA_i,
    input  logic             invB_i,
    output logic [WIDTH-1:0] res_o,
    output logic             cout_o,
    output logic             ofl_o
);

    logic [WIDTH:0] sum;

    // Select the op result; carry and overflow only mean something for ADD.
    always_comb begin
        sum    = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
        res_o  = '0;
        cout_o = 1'b0;
        ofl_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                res_o  = sum[WIDTH-1:0];
                cout_o = sum[WIDTH];
                ofl_o  = addOverflow(sign_i, a_i[WIDTH-1], b_i[WIDTH-1],
                                     sum[WIDTH-1], sum[WIDTH], invA_i, invB_i);
            end
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_AND:  res_o = a_i & b_i;
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle WISC ALU with registered results and valid/ready handshakes on
// both sides. Shifts are iterative (one bit per cycle) by default; defining
// ALU_BARREL_EN replaces them with a combinational barrel shifter so every
// op completes on the accept edge.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [2:0]       Op,
    input  logic             invA,
    input  logic             invB,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Ofl,
    output logic             Z
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ofl_q, ofl_d;
    logic             z_q, z_d;

    logic [WIDTH-1:0] aPrep, bPrep;
    logic [SHW-1:0]   shAmt;
    logic             isShift;
    logic             accept;
    logic             goShift;
    logic [WIDTH-1:0] shiftRes;
    logic [WIDTH-1:0] immOut;

    logic [WIDTH-1:0] coreRes;
    logic             coreOfl;
    logic             unusedCout;

    // The shift amount always comes from raw B; only the operands are inverted.
    assign aPrep   = invA ? ~A : A;
    assign bPrep   = invB ? ~B : B;
    assign shAmt   = B[SHW-1:0];
    assign isShift = ~Op[2];
    assign accept  = in_valid & in_ready;

    alu_core_comb #(.WIDTH(WIDTH)) uCore (
        .a_i    (aPrep),
        .b_i    (bPrep),
        .cin_i  (Cin),
        .op_i   (Op),
        .sign_i (sign),
        .invA_i (invA),
        .invB_i (invB),
        .res_o  (coreRes),
        .cout_o (unusedCout),
        .ofl_o  (coreOfl)
    );

`ifdef ALU_BARREL_EN
    // Log-depth shifter: stage s moves the value by 2**s when bit s of n is set.
    function automatic logic [WIDTH-1:0] barrelShift(
        input logic [1:0]       kind,
        input logic [WIDTH-1:0] v,
        input logic [SHW-1:0]   n
    );
        logic [WIDTH-1:0] r;
        r = v;
        for (int s = 0; s < SHW; s++) begin
            if (n[s]) begin
                case (kind)
                    2'b00:   r = (r << (1 << s)) | (r >> (WIDTH - (1 << s)));
                    2'b01:   r = r << (1 << s);
                    2'b10:   r = (r >> (1 << s)) | (r << (WIDTH - (1 << s)));
                    default: r = r >> (1 << s);
                endcase
            end
        end
        return r;
    endfunction

    assign goShift  = 1'b0;
    assign shiftRes = barrelShift(Op[1:0], aPrep, shAmt);
`else
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       shOp_q, shOp_d;
    logic [WIDTH-1:0] stepVal;

    // One bit position of the selected shift or rotate.
    function automatic logic [WIDTH-1:0] stepOnce(
        input logic [1:0]       kind,
        input logic [WIDTH-1:0] v
    );
        case (kind)
            2'b00:   return {v[WIDTH-2:0], v[WIDTH-1]};
            2'b01:   return {v[WIDTH-2:0], 1'b0};
            2'b10:   return {v[0], v[WIDTH-1:1]};
            default: return {1'b0, v[WIDTH-1:1]};
        endcase
    endfunction

    assign goShift  = isShift && (shAmt != '0);
    assign shiftRes = aPrep;
    assign stepVal  = stepOnce(shOp_q, work_q);

    // Load the work register on a multi-cycle shift, then step it once per cycle.
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        shOp_d = shOp_q;
        if (accept && goShift) begin
            work_d = aPrep;
            cnt_d  = shAmt;
            shOp_d = Op[1:0];
        end else if (state_q == ST_SHIFT) begin
            work_d = stepVal;
            cnt_d  = cnt_q - SHW'(1);
        end
    end

    // Shifter working state; cleared on reset so an aborted shift leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q <= '0;
            cnt_q  <= '0;
            shOp_q <= '0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            shOp_q <= shOp_d;
        end
    end
`endif

    assign immOut = isShift ? shiftRes : coreRes;

    // Capture single-cycle results on accept, or the final step of an iterative shift.
    always_comb begin
        out_d = out_q;
        ofl_d = ofl_q;
        z_d   = z_q;
        if (accept && !goShift) begin
            out_d = immOut;
            ofl_d = coreOfl;
            z_d   = (immOut == '0);
        end
`ifndef ALU_BARREL_EN
        else if (state_q == ST_SHIFT && cnt_q == SHW'(1)) begin
            out_d = stepVal;
            ofl_d = 1'b0;
            z_d   = (stepVal == '0);
        end
`endif
    end

    // Result registers; they only change when a new result is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            ofl_q <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            out_q <= out_d;
            ofl_q <= ofl_d;
            z_q   <= z_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an accept behaves the same from IDLE or from a draining DONE.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = goShift ? ST_SHIFT : ST_DONE;
        end else begin
            case (state_q)
                ST_SHIFT: begin
`ifdef ALU_BARREL_EN
                    state_d = ST_IDLE;
`else
                    if (cnt_q == SHW'(1)) begin
                        state_d = ST_DONE;
                    end
`endif
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = !rst && ((state_q == ST_IDLE) ||
                             ((state_q == ST_DONE) && out_ready));
        out_valid = (state_q == ST_DONE);
    end

    assign Out = out_q;
    assign Ofl = ofl_q;
    assign Z   = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=16. Stimulus pushes expected results
// (from a plain-arithmetic reference model) into a queue; a monitor pops and
// compares on every output handshake, including the cycle the result appeared.
module tb_alu_seq;

    localparam int WIDTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Cin = 1'b0;
    logic [2:0]  Op = '0;
    logic        invA = 1'b0;
    logic        invB = 1'b0;
    logic        sign = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] Out;
    logic        Ofl;
    logic        Z;

    typedef struct {
        logic [15:0] out;
        logic        ofl;
        logic        z;
        int          readyEdge;
    } exp_t;

    exp_t sbQ[$];
    exp_t mon;
    int   asserts   = 0;
    int   failures  = 0;
    int   cycle     = 0;
    int   readyMode = 0;
    int   seenValid = 0;
    int   validEdge = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Op        (Op),
        .invA      (invA),
        .invB      (invB),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .Ofl       (Ofl),
        .Z         (Z)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model straight from the op definitions, using 32-bit integers.
    function automatic exp_t refModel(input logic [15:0] a, input logic [15:0] b,
                                      input logic cin, input logic [2:0] op,
                                      input logic ia, input logic ib,
                                      input logic sg, output int lat);
        exp_t        e;
        logic [15:0] a2, b2;
        int unsigned ap, bp, n, r, sum;
        int          sa, sb, ss;
        a2 = ia ? ~a : a;
        b2 = ib ? ~b : b;
        ap = a2;
        bp = b2;
        n  = b[3:0];
        r  = 0;
        sum = 0;
        e.ofl = 1'b0;
        case (op)
            3'd0: r = ((ap << n) | (ap >> (16 - n))) & 32'hFFFF;
            3'd1: r = (ap << n) & 32'hFFFF;
            3'd2: r = ((ap >> n) | (ap << (16 - n))) & 32'hFFFF;
            3'd3: r = ap >> n;
            3'd4: begin
                sum = ap + bp + cin;
                r   = sum & 32'hFFFF;
                if (sg) begin
                    sa = (ap >= 32768) ? int'(ap) - 65536 : int'(ap);
                    sb = (bp >= 32768) ? int'(bp) - 65536 : int'(bp);
                    ss = sa + sb + int'(cin);
                    e.ofl = (ss > 32767) || (ss < -32768);
                end else begin
                    e.ofl = sum[16] ^ (ia ^ ib);
                end
            end
            3'd5: r = ap | bp;
            3'd6: r = ap ^ bp;
            default: r = ap & bp;
        endcase
        e.out = r[15:0];
        e.z   = (r == 0);
        e.readyEdge = 0;
`ifdef ALU_BARREL_EN
        lat = 0;
`else
        lat = (op < 4 && n != 0) ? int'(n) : 0;
`endif
        return e;
    endfunction

    // Called at a falling edge: present one op, wait for acceptance, queue the expectation.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic [2:0] op,
                                 input logic ia, input logic ib, input logic sg,
                                 input logic haveExp, input logic [15:0] expOut,
                                 input logic expOfl, input logic expZ,
                                 output int waits);
        exp_t e;
        int   lat;
        A = a; B = b; Cin = cin; Op = op;
        invA = ia; invB = ib; sign = sg;
        in_valid = 1'b1;
        waits = 0;
        #1;
        while (!in_ready && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            asserts++;
            failures++;
            $display("[TB] FAIL acceptTimeout: got in_ready=0 after %0d cycles, expected 1", waits);
        end else begin
            e = refModel(a, b, cin, op, ia, ib, sg, lat);
            if (haveExp) begin
                e.out = expOut;
                e.ofl = expOfl;
                e.z   = expZ;
            end
            e.readyEdge = cycle + 1 + lat;
            sbQ.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int k = 0;
        while (sbQ.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (sbQ.size() != 0) begin
            asserts++;
            failures++;
            $display("[TB] FAIL drainTimeout: got %0d pending results, expected 0", sbQ.size());
        end
    endtask

    // Consumer side: out_ready always high, random, or held low.
    initial begin
        forever begin
            @(negedge clk);
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare each result as it is taken, plus the edge it first appeared.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                seenValid = 0;
            end else begin
                if (out_valid && seenValid == 0) begin
                    seenValid = 1;
                    validEdge = cycle;
                end
                if (out_valid && out_ready) begin
                    if (sbQ.size() == 0) begin
                        asserts++;
                        failures++;
                        $display("[TB] FAIL unexpectedOutput: got Out=0x%0h, expected no result", Out);
                    end else begin
                        mon = sbQ.pop_front();
                        checkOutput("Out", 32'(Out), 32'(mon.out));
                        checkOutput("Ofl", 32'(Ofl), 32'(mon.ofl));
                        checkOutput("Z", 32'(Z), 32'(mon.z));
                        checkOutput("validEdge", validEdge, mon.readyEdge);
                    end
                    seenValid = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rstOutValid", 32'(out_valid), 0);
        checkOutput("rstOut", 32'(Out), 0);
        checkOutput("rstOfl", 32'(Ofl), 0);
        checkOutput("rstZ", 32'(Z), 0);
        checkOutput("rstInReady", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        readyMode = 0;
        #1;
        checkOutput("idleInReady", 32'(in_ready), 1);
        @(negedge clk);

        // Back-to-back directed ops.
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1,
                      1'b1, 16'h8000, 1'b1, 1'b0, w);
        applyStimulus(16'h0005, 16'h0005, 1'b1, 3'b100, 1'b0, 1'b1, 1'b0,
                      1'b1, 16'h0000, 1'b0, 1'b1, w);
        applyStimulus(16'h8001, 16'h0004, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0,
                      1'b1, 16'h0018, 1'b0, 1'b0, w);
`ifndef ALU_BARREL_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("shiftInReady", 32'(in_ready), 0);
            @(negedge clk);
        end
`endif
        applyStimulus(16'hA5A5, 16'h0010, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0,
                      1'b1, 16'hA5A5, 1'b0, 1'b0, w);
        waitDrain();

        // Backpressure on an AND result, then a same-cycle XOR accept.
        readyMode = 2;
        out_ready = 1'b0;
        applyStimulus(16'h00FF, 16'h0FF0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0,
                      1'b1, 16'h00F0, 1'b0, 1'b0, w);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("holdOut", 32'(Out), 32'h00F0);
            checkOutput("holdValid", 32'(out_valid), 1);
            checkOutput("holdInReady", 32'(in_ready), 0);
            @(negedge clk);
        end
        readyMode = 0;
        out_ready = 1'b1;
        applyStimulus(16'h1234, 16'h00FF, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0,
                      1'b1, 16'h12CB, 1'b0, 1'b0, w);
        checkOutput("xorWaits", w, 0);
        waitDrain();

        // Reset in the middle of a long shift.
        applyStimulus(16'h1234, 16'h0007, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0,
                      1'b0, 16'h0000, 1'b0, 1'b0, w);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        sbQ.delete();
        checkOutput("midRstValid", 32'(out_valid), 0);
        checkOutput("midRstOut", 32'(Out), 0);
        checkOutput("midRstInReady", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("postRstInReady", 32'(in_ready), 1);
        checkOutput("postRstValid", 32'(out_valid), 0);
        @(negedge clk);
        applyStimulus(16'h0100, 16'h0023, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0,
                      1'b1, 16'h0123, 1'b0, 1'b0, w);
        waitDrain();

        // Randomized ops with a random consumer.
        readyMode = 1;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom),
                          3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'b0, 16'h0000, 1'b0, 1'b0, w);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
            end
        end
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the 16-bit combinational WISC ALU.
- Provides the same op set (rotate/shift, ADD, OR, XOR, AND), operand inversion, carry-in, signed/unsigned overflow and zero flag.
- Adds registered results, valid/ready handshakes on both sides, and an iterative shifter.
- Sits between decode/register-read and writeback in the execute stage; the stall logic observes in_ready.

Parameters:
- WIDTH, 16, datapath width. Power of 2, at least 4.
- SHW = $clog2(WIDTH) is a derived localparam, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B; B[SHW-1:0] is the shift amount
- Cin  in  1  adder carry-in
- Op  in  3  000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 ADD, 101 OR, 110 XOR, 111 AND
- invA  in  1  invert A before the op
- invB  in  1  invert B before non-shift ops
- sign  in  1  1 signed, 0 unsigned overflow rule
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- Out  out  WIDTH  registered result
- Ofl  out  1  registered overflow
- Z  out  1  registered zero flag (Out == 0)

Behaviour:
- Reset (asynchronous, active-high): state IDLE; out_valid=0, Out=0, Ofl=0, Z=0, shift counter 0. in_ready=0 while rst is high. Reset mid-shift or in DONE discards the operation with no output.
- Operand prep: A' = invA ? ~A : A. B' = invB ? ~B : B. Shift amount n = B[SHW-1:0] (raw B, never inverted).
- in_ready = !rst && (state==IDLE || (state==DONE && out_ready)).
- Accept = in_valid && in_ready, registered inputs latched on that edge (edge 0).
- States: IDLE, SHIFT, DONE.
- Non-shift op, or shift with n==0: result registered on edge 0; enter DONE. For a shift with n==0, Out=A'.
- Shift with n>0: work register loaded with A' and counter with n on edge 0; enter SHIFT.
- SHIFT: one bit position per cycle; counter decrements. The edge on which the counter reaches 0 writes Out/Z and enters DONE. out_valid rises after edge n; in_ready=0 throughout SHIFT.
- Shift fill rules: SLL fills 0 at LSB; SRL fills 0 at MSB; ROL/ROR rotate.
- ADD: {Cout,Out} = A' + B' + Cin at WIDTH+1 bits.
  - Signed Ofl = (A'[MSB]==B'[MSB]) && (Out[MSB]!=A'[MSB]).
  - Unsigned Ofl = Cout ^ (invA ^ invB).
- Ofl=0 for all non-ADD ops. Cin is ignored for non-ADD ops.
- DONE: out_valid=1; Out/Ofl/Z held stable while out_ready=0.
  - out_ready=1 and no accept: go to IDLE, out_valid=0.
  - out_ready=1 with accept in the same cycle: the new op is processed as if from IDLE, with no bubble for single-cycle ops.
- in_valid while in_ready=0: ignored. The upstream stage must hold its inputs.

Optional Feature:
- Macro: ALU_BARREL_EN.
- Defined: shifts use a combinational log-depth barrel shifter. All ops, including shifts of any n, complete on edge 0; state SHIFT and the counter are not generated.
- Undefined: iterative shifter as described above, with latency n cycles.
- Flags and handshake rules are identical in both builds.

Decomposition:
- Package alu_pkg:
  - Op encodings as localparams OP_ROL … OP_AND.
  - State encodings ST_IDLE/ST_SHIFT/ST_DONE.
  - Function for unsigned/signed overflow.
- One sub-module, alu_core_comb: combinational WIDTH-bit add/or/xor/and with Cout and Ofl. It is instantiated once; the parent holds the state machine, shifter and output registers.

Test Plan (WIDTH=16):
- ADD overflow: A=0x7FFF, B=0x0001, sign=1, Cin=0 -> Out=0x8000, Ofl=1, Z=0, out_valid after edge 0.
- SUB zero: A=0x0005, B=0x0005, invB=1, Cin=1, Op=100, sign=0 -> Out=0x0000, Z=1, Ofl=0.
- ROL iterative: A=0x8001, B=0x0004, Op=000 -> in_ready=0 for 4 cycles, out_valid after edge 4, Out=0x0018. With ALU_BARREL_EN: same result after edge 0.
- ROR/SRL with n=0: A=0xA5A5, B=0x0010, Op=011 -> Out=0xA5A5 after edge 0, Z=0.
- Backpressure: hold out_ready=0 for 3 cycles after an AND result of 0x00F0 -> Out stays 0x00F0, in_ready=0. Then out_ready=1 with in_valid=1 and an XOR op -> accepted the same cycle, new result next cycle.
- Reset mid-shift: SLL with n=7, assert rst after 3 cycles -> out_valid=0, Out=0 immediately. After release, in_ready=1 and the next ADD completes normally.
